dmem_arbiter: RTL and testbench

- Two-requester arbiter and load/store sequencer in front of the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the DMA/debug port.
- Grants one access per cycle and translates size/alignment into the memory's 2-bit store-enable code (00 none, 01 word, 10 half, 11 byte).
- Returns a registered, lane-extracted and sign/zero-extended load response with an error flag.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_rr_arb.sv | 38 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   size_e      : request access size (byte/half/word; 2'b11 is illegal)
//   mem_we_e    : store-enable code presented to the data memory
//   size_to_we  : maps an access size to its store-enable code
//   load_extend : lane extraction plus sign/zero extension of a load
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_WORD = 2'b01,
    WE_HALF = 2'b10,
    WE_BYTE = 2'b11
  } mem_we_e;

  function automatic mem_we_e size_to_we(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_we = WE_BYTE;
      SZ_HALF: size_to_we = WE_HALF;
      SZ_WORD: size_to_we = WE_WORD;
      default: size_to_we = WE_NONE;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = rd >> {addr_lo, 3'b000};
    half_sh = rd >> {addr_lo[1], 4'b0000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'h0, byte_sh[7:0]}
                                 : {{24{byte_sh[7]}}, byte_sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'h0, half_sh[15:0]}
                                 : {{16{half_sh[15]}}, half_sh[15:0]};
      SZ_WORD: load_extend = rd;
      default: load_extend = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant logic with a round-robin pointer flop.
//   clk, rst_n : clock, async active-low reset
//   valid[1:0] : per-requester request valid
//   grant[1:0] : one-hot (or zero) combinational grant
// PRIO_FIXED=1 makes requester 0 always win a contest.
module dmem_rr_arb #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (rst_n) begin
      if (valid == 2'b11) begin
        if (PRIO_FIXED != 0) grant = 2'b01;
        else                 grant = rr_ptr_q ? 2'b10 : 2'b01;
        // pointer moves to the loser only on a contested grant
        rr_ptr_d = grant[0];
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter / load-store sequencer for the single-port data memory.
//   req_*     : per-requester request (0 = core LSU, 1 = DMA/debug)
//   rsp_*     : registered response, one cycle after the grant edge
//   mem_*     : memory interface (mem_rd is combinational read data)
// Optional: define DMEM_ARB_STATS_EN to add saturating stat_* counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned PRIO_FIXED  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][1:0]  req_size,
  input  logic [1:0]       req_unsigned,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [1:0]       mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grants0,
  output logic [31:0]      stat_grants1,
  output logic [31:0]      stat_conflicts,
  output logic [31:0]      stat_errors
`endif
);

  logic [1:0]  grant;
  logic        sel;
  logic        any_grant;
  logic        illegal;
  logic [1:0]  g_size;
  logic [31:0] g_addr;

  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;

  dmem_rr_arb #(.PRIO_FIXED(PRIO_FIXED)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign sel       = grant[1];

  always_comb begin
    g_size      = req_size[sel];
    g_addr      = req_addr[sel];
    illegal     = (g_size == 2'b11) ||
                  (g_size == SZ_HALF && g_addr[0]) ||
                  (g_size == SZ_WORD && g_addr[1:0] != 2'b00) ||
                  ({2'b00, g_addr[31:2]} >= DEPTH_WORDS);
    mem_we      = WE_NONE;
    mem_a       = '0;
    mem_wd      = '0;
    rsp_valid_d = grant;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (any_grant) begin
      mem_a     = g_addr;
      mem_wd    = req_wdata[sel];
      rsp_err_d = illegal;
      if (req_we[sel] && !illegal) mem_we = size_to_we(g_size);
      if (!req_we[sel] && !illegal)
        rsp_rdata_d = load_extend(mem_rd, g_addr[1:0], g_size, req_unsigned[sel]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] g0_q, g0_d, g1_q, g1_d, cf_q, cf_d, er_q, er_d;

  always_comb begin
    g0_d = g0_q;
    g1_d = g1_q;
    cf_d = cf_q;
    er_d = er_q;
    if (grant[0] && g0_q != '1)             g0_d = g0_q + 32'd1;
    if (grant[1] && g1_q != '1)             g1_d = g1_q + 32'd1;
    if (req_valid == 2'b11 && cf_q != '1)   cf_d = cf_q + 32'd1;
    if (any_grant && illegal && er_q != '1) er_d = er_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g0_q <= '0;
      g1_q <= '0;
      cf_q <= '0;
      er_q <= '0;
    end else begin
      g0_q <= g0_d;
      g1_q <= g1_d;
      cf_q <= cf_d;
      er_q <= er_d;
    end
  end

  assign stat_grants0   = g0_q;
  assign stat_grants1   = g1_q;
  assign stat_conflicts = cf_q;
  assign stat_errors    = er_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, req_unsigned;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [1:0]       mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [1:0]       p_req_valid, p_req_ready, p_req_we, p_req_unsigned;
  logic [1:0][1:0]  p_req_size;
  logic [1:0][31:0] p_req_addr, p_req_wdata;
  logic [1:0]       p_rsp_valid;
  logic [31:0]      p_rsp_rdata;
  logic             p_rsp_err;
  logic [1:0]       p_mem_we;
  logic [31:0]      p_mem_a, p_mem_wd, p_mem_rd;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_g0, st_g1, st_cf, st_er;
  logic [31:0] p_st_g0, p_st_g1, p_st_cf, p_st_er;
`endif

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.DEPTH_WORDS(64), .PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .stat_grants0(st_g0), .stat_grants1(st_g1),
    .stat_conflicts(st_cf), .stat_errors(st_er)
`endif
  );

  dmem_arbiter #(.DEPTH_WORDS(64), .PRIO_FIXED(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
    .req_size(p_req_size), .req_unsigned(p_req_unsigned), .req_addr(p_req_addr),
    .req_wdata(p_req_wdata), .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata),
    .rsp_err(p_rsp_err), .mem_we(p_mem_we), .mem_a(p_mem_a), .mem_wd(p_mem_wd),
    .mem_rd(p_mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .stat_grants0(p_st_g0), .stat_grants1(p_st_g1),
    .stat_conflicts(p_st_cf), .stat_errors(p_st_er)
`endif
  );

  // Data memory model: combinational read, write on the clock edge.
  logic [31:0] mem [0:63];
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    case (mem_we)
      2'b01: mem[mem_a[7:2]] <= mem_wd;
      2'b10: if (mem_a[1]) mem[mem_a[7:2]][31:16] <= mem_wd[15:0];
             else          mem[mem_a[7:2]][15:0]  <= mem_wd[15:0];
      2'b11: case (mem_a[1:0])
               2'b00: mem[mem_a[7:2]][7:0]   <= mem_wd[7:0];
               2'b01: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
               2'b10: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
               default: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
             endcase
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          rq;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_we;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input string n, input int rq, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] ewe, input logic [31:0] erd, input logic eerr);
    vq.push_back('{n, rq, we, sz, uns, a, wd, ewe, erd, eerr});
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] onehot;
    onehot = 2'(1 << v.rq);
    @(negedge clk);
    req_we[v.rq]       = v.we;
    req_size[v.rq]     = v.size;
    req_unsigned[v.rq] = v.uns;
    req_addr[v.rq]     = v.addr;
    req_wdata[v.rq]    = v.wdata;
    req_valid          = onehot;
    #1;
    chk({v.name, ".ready"}, {30'b0, req_ready}, {30'b0, onehot});
    chk({v.name, ".mem_we"}, {30'b0, mem_we}, {30'b0, v.exp_we});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk({v.name, ".rsp_valid"}, {30'b0, rsp_valid}, {30'b0, onehot});
    chk({v.name, ".rdata"}, rsp_rdata, v.exp_rd);
    chk({v.name, ".err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
  endtask

  initial begin
    logic [1:0] alt [4];
    alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0;
    req_addr = '0; req_wdata = '0;
    p_req_valid = '0; p_req_we = '0; p_req_size = '0; p_req_unsigned = '0;
    p_req_addr = '0; p_req_wdata = '0; p_mem_rd = '0;

    //            name       rq we size  u  addr          wdata         we     rdata         err
    add("sw_10",     0, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 2'b01, 32'h0,        0);
    add("lb_11",     0, 0, 2'b00, 0, 32'h11,  32'h0,        2'b00, 32'hFFFFFFBE, 0);
    add("lbu_11",    0, 0, 2'b00, 1, 32'h11,  32'h0,        2'b00, 32'h000000BE, 0);
    add("lh_12",     0, 0, 2'b01, 0, 32'h12,  32'h0,        2'b00, 32'hFFFFDEAD, 0);
    add("lhu_10_r1", 1, 0, 2'b01, 1, 32'h10,  32'h0,        2'b00, 32'h0000BEEF, 0);
    add("lw_10_r1",  1, 0, 2'b10, 0, 32'h10,  32'h0,        2'b00, 32'hDEADBEEF, 0);
    add("sh_mis",    0, 1, 2'b01, 0, 32'h3,   32'h1234,     2'b00, 32'h0,        1);
    add("sw_mis",    0, 1, 2'b10, 0, 32'h2,   32'hCAFEF00D, 2'b00, 32'h0,        1);
    add("st_sz11",   0, 1, 2'b11, 0, 32'h10,  32'h0,        2'b00, 32'h0,        1);
    add("ld_sz11",   0, 0, 2'b11, 0, 32'h10,  32'h0,        2'b00, 32'h0,        1);
    add("lw_10_chk", 0, 0, 2'b10, 0, 32'h10,  32'h0,        2'b00, 32'hDEADBEEF, 0);
    add("sw_fc",     0, 1, 2'b10, 0, 32'hFC,  32'h0BADF00D, 2'b01, 32'h0,        0);
    add("lw_fc",     0, 0, 2'b10, 0, 32'hFC,  32'h0,        2'b00, 32'h0BADF00D, 0);
    add("lb_ff",     0, 0, 2'b00, 0, 32'hFF,  32'h0,        2'b00, 32'h0000000B, 0);
    add("lh_fc",     0, 0, 2'b01, 0, 32'hFC,  32'h0,        2'b00, 32'hFFFFF00D, 0);
    add("lw_100",    0, 0, 2'b10, 0, 32'h100, 32'h0,        2'b00, 32'h0,        1);
    add("sw_100",    0, 1, 2'b10, 0, 32'h100, 32'h12345678, 2'b00, 32'h0,        1);
    add("lw_0_chk",  0, 0, 2'b10, 0, 32'h0,   32'h0,        2'b00, 32'h0,        0);
    add("sw_20_r1",  1, 1, 2'b10, 0, 32'h20,  32'h11223344, 2'b01, 32'h0,        0);
    add("sb_21",     0, 1, 2'b00, 0, 32'h21,  32'hAAAAAA55, 2'b11, 32'h0,        0);
    add("lw_20",     0, 0, 2'b10, 0, 32'h20,  32'h0,        2'b00, 32'h11225544, 0);
    add("sh_22_r1",  1, 1, 2'b01, 0, 32'h22,  32'h0000ABCD, 2'b10, 32'h0,        0);
    add("lw_20_b",   0, 0, 2'b10, 0, 32'h20,  32'h0,        2'b00, 32'hABCD5544, 0);
    add("lb_20",     0, 0, 2'b00, 0, 32'h20,  32'h0,        2'b00, 32'h00000044, 0);

    // Reset state, including a valid request held during reset.
    #2;
    chk("rst.rsp_valid", {30'b0, rsp_valid}, 32'h0);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.err", {31'b0, rsp_err}, 32'h0);
    req_valid = 2'b01;
    req_we = 2'b01; req_size[0] = 2'b10; req_addr[0] = 32'h40; req_wdata[0] = 32'h99;
    #1;
    chk("rst.ready", {30'b0, req_ready}, 32'h0);
    chk("rst.mem_we", {30'b0, mem_we}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00; req_we = 2'b00;
    rst_n = 1'b1;
    chk("rst.no_write", mem[16], 32'h0);

    foreach (vq[i]) run_vec(vq[i]);

    @(posedge clk);
    #1;
    chk("pulse_one_cycle", {30'b0, rsp_valid}, 32'h0);

    // Contested grant moves rr_ptr to 1; reset in the following cycle.
    @(negedge clk);
    req_we = 2'b01;
    req_size[0] = 2'b10; req_addr[0] = 32'h30; req_wdata[0] = 32'h00000077;
    req_size[1] = 2'b10; req_addr[1] = 32'h10; req_unsigned = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("pre.ready", {30'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.rsp_valid", {30'b0, rsp_valid}, 32'h0);
    chk("midrst.ready", {30'b0, req_ready}, 32'h0);
    chk("midrst.mem_we", {30'b0, mem_we}, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("midrst.st_g0", st_g0, 32'h0);
    chk("midrst.st_cf", st_cf, 32'h0);
    chk("midrst.st_er", st_er, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    p_req_size[0] = 2'b10; p_req_size[1] = 2'b10;
    p_req_valid = 2'b11;

    // Contention: alternation from rr_ptr=0, fixed priority on the other DUT.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr.ready%0d", i), {30'b0, req_ready}, {30'b0, alt[i]});
      chk($sformatf("fix.ready%0d", i), {30'b0, p_req_ready}, 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("rr.rsp%0d", i), {30'b0, rsp_valid}, {30'b0, alt[i]});
      @(negedge clk);
    end
    req_valid = 2'b00;
    p_req_valid = 2'b00;
`ifdef DMEM_ARB_STATS_EN
    chk("st_cf", st_cf, 32'd4);
    chk("st_g0", st_g0, 32'd2);
`endif

    // Data stored by the contested requester 0 must be visible.
    run_vec('{"lw_30", 0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 2'b00, 32'h00000077, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
